// File: rtl/rom_download_packer.sv
// Packs the HPS ROM download byte stream little-endian into 32-bit words, buffers them
// in a small FIFO and issues each word as an SDRAM write over the req/ack handshake.
module rom_download_packer #(
  parameter logic [22:0] ADDR_OFFSET = 23'd0,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [7:0]  PAD_BYTE    = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic        ioctl_wr,
  input  logic        ioctl_download,
  output logic        ioctl_wait,
  output logic [22:0] sdram_addr,
  output logic [31:0] sdram_data,
  output logic        sdram_we,
  output logic        sdram_req,
  input  logic        sdram_ack,
  output logic        busy,
  output logic        done,
  output logic        overflow
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  logic [31:0]   asm_q, asm_d;
  logic [3:0]    mask_q, mask_d, base_mask;
  logic [17:0]   waddr_q, waddr_d;
  logic          dl_q, pend_q, pend_d;
  logic [1:0]    lane;
  logic          rise, fall;

  logic          push, push_ok, pop, full;
  logic [3:0]    push_mask;
  logic [31:0]   push_dat;
  logic [17:0]   push_waddr;
  logic [54:0]   push_word, head;

  logic [54:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          wait_q, ovf_q;

  state_t        state_q, state_d;
  logic          load, req_q, req_d;
  logic [22:0]   addr_q;
  logic [31:0]   data_q;
  logic          busy_q, done_q, done_set;

  function automatic logic [31:0] pad_word(input logic [31:0] w, input logic [3:0] m);
    logic [31:0] r;
    for (int n = 0; n < 4; n++) r[8*n +: 8] = m[n] ? w[8*n +: 8] : PAD_BYTE;
    return r;
  endfunction

  // Byte assembly: at most one word leaves per cycle (lane-3 fill, address jump or download end).
  always_comb begin
    lane       = ioctl_addr[1:0];
    rise       = ioctl_download & ~dl_q;
    fall       = ~ioctl_download & dl_q;
    base_mask  = rise ? 4'b0 : mask_q;
    asm_d      = asm_q;
    mask_d     = base_mask;
    waddr_d    = waddr_q;
    push       = 1'b0;
    push_mask  = base_mask;
    push_dat   = asm_q;
    push_waddr = waddr_q;
    if (ioctl_wr) begin
      if (base_mask != 4'b0 && ioctl_addr[19:2] != waddr_q) begin
        push                     = 1'b1;
        mask_d                   = 4'b0001 << lane;
        waddr_d                  = ioctl_addr[19:2];
        asm_d[{lane, 3'b000} +: 8] = ioctl_data;
      end else begin
        if (base_mask == 4'b0) waddr_d = ioctl_addr[19:2];
        asm_d[{lane, 3'b000} +: 8] = ioctl_data;
        mask_d = base_mask | (4'b0001 << lane);
        if (lane == 2'd3) begin
          push       = 1'b1;
          push_mask  = mask_d;
          push_dat   = asm_d;
          push_waddr = waddr_d;
          mask_d     = 4'b0;
        end
      end
    end
    if (fall && !push && mask_d != 4'b0) begin
      push       = 1'b1;
      push_mask  = mask_d;
      push_dat   = asm_d;
      push_waddr = waddr_d;
      mask_d     = 4'b0;
    end
  end

  assign push_word = {ADDR_OFFSET + {4'b0, push_waddr, 1'b0}, pad_word(push_dat, push_mask)};
  assign head      = mem_q[rptr_q];
  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign push_ok   = push & (~full | pop);
  assign count_d   = count_q + CW'(push_ok) - CW'(pop);

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: if (count_q != '0) begin
        load    = 1'b1;
        state_d = S_REQ;
      end
      S_REQ: if (sdram_ack) begin
        pop     = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req_d    = load | (req_q & ~pop);
  assign done_set = pend_q & ~ioctl_download & ~ioctl_wr & (mask_q == 4'b0) &
                    (count_q == '0) & (state_q == S_IDLE) & ~req_q;
  assign pend_d   = done_set ? 1'b0 : (pend_q | rise);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // dl_q resets high so a download already in progress at reset release never arms done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      asm_q   <= '0;
      mask_q  <= '0;
      waddr_q <= '0;
      dl_q    <= 1'b1;
      pend_q  <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      wait_q  <= 1'b0;
      ovf_q   <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      asm_q   <= asm_d;
      mask_q  <= mask_d;
      waddr_q <= waddr_d;
      dl_q    <= ioctl_download;
      pend_q  <= pend_d;
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop)     rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
      wait_q  <= (count_d == CW'(FIFO_DEPTH));
      ovf_q   <= ovf_q | (push & ~push_ok);
      req_q   <= req_d;
      if (load) begin
        addr_q <= head[54:32];
        data_q <= head[31:0];
      end
      busy_q  <= ioctl_download | (mask_d != 4'b0) | (count_d != '0) | req_d;
      done_q  <= done_set;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= push_word;
  end

  assign ioctl_wait = wait_q;
  assign sdram_addr = addr_q;
  assign sdram_data = data_q;
  assign sdram_req  = req_q;
  assign sdram_we   = req_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign overflow   = ovf_q;

endmodule
